// File: rtl/raw_hazard_tracker.sv
// rtl/raw_hazard_tracker.sv - decode-stage read-after-write hazard detector
//
// Tracks the destination register of each instruction issued from ID across
// three in-flight slots aligned with EX, MEM and WB. It stalls the ID
// instruction while any of its source registers is still being produced.
// The pipeline has no forwarding, so this block is the only RAW protection.
//
// Parameters:
//   WB_BYPASS      1: the register file writes before it reads, so WB is not
//                     compared. 0: WB is compared as well.
//   CNT_W          width of the saturating stall-cycle counter.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset, overrides all other inputs
//   id_valid       ID holds a real instruction (not a bubble)
//   id_dest_reg    destination register of the ID instruction
//   id_dest_valid  ID instruction writes the register file
//   id_src1        first source register
//   id_src1_valid  first source register is actually read
//   id_src2        second source register
//   id_src2_valid  second source register is actually read
//   flush          taken branch/jump kills the ID instruction this cycle
//   ext_stall      global freeze; all tracker state holds
//   stall          hold PC and IF/ID, inject a bubble into ID/EX
//   inflight_valid slot valid bits {WB, MEM, EX}
//   stall_count    number of cycles in which a hazard stall was applied

module raw_hazard_tracker #(
   parameter int WB_BYPASS = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [2:0]       id_dest_reg,
   input  logic             id_dest_valid,
   input  logic [2:0]       id_src1,
   input  logic             id_src1_valid,
   input  logic [2:0]       id_src2,
   input  logic             id_src2_valid,
   input  logic             flush,
   input  logic             ext_stall,
   output logic             stall,
   output logic [2:0]       inflight_valid,
   output logic [CNT_W-1:0] stall_count
);

   // Number of slots compared against the ID sources. With a write-before-read
   // register file, the WB slot (index 2) already delivers its value to ID.
   localparam int N_CHK = (WB_BYPASS != 0) ? 2 : 3;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Slot state: index 0 = EX, 1 = MEM, 2 = WB.
   logic [2:0]       r_slot_valid;
   logic [2:0]       r_slot_reg [3];
   logic [CNT_W-1:0] r_stall_count;

   // Per-slot match flags for each source operand.
   logic [2:0] w_hit_src1;
   logic [2:0] w_hit_src2;
   logic       w_src1_hazard;
   logic       w_src2_hazard;
   logic       w_stall;
   logic       w_issue;

   always_comb begin
      w_hit_src1 = 3'b000;
      w_hit_src2 = 3'b000;
      for (int s = 0; s < 3; s++) begin
         if (s < N_CHK) begin
            // R0 is an ordinary register here; there is no hardwired zero.
            w_hit_src1[s] = r_slot_valid[s] && (r_slot_reg[s] == id_src1);
            w_hit_src2[s] = r_slot_valid[s] && (r_slot_reg[s] == id_src2);
         end
      end
   end

   // The ID instruction's own destination is never compared against its
   // sources: a same-instruction dependency reads the old value by design.
   assign w_src1_hazard = id_src1_valid && (w_hit_src1 != 3'b000);
   assign w_src2_hazard = id_src2_valid && (w_hit_src2 != 3'b000);

   // A flushed instruction is dead, so it must never hold the front end.
   assign w_stall = id_valid && !flush && (w_src1_hazard || w_src2_hazard);

   // Only a live, non-stalled, non-flushed writer occupies the EX slot.
   assign w_issue = id_valid && id_dest_valid && !w_stall && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_valid  <= 3'b000;
         r_slot_reg[0] <= 3'd0;
         r_slot_reg[1] <= 3'd0;
         r_slot_reg[2] <= 3'd0;
         r_stall_count <= '0;
      end else if (!ext_stall) begin
         r_slot_valid[2] <= r_slot_valid[1];
         r_slot_reg[2]   <= r_slot_reg[1];
         r_slot_valid[1] <= r_slot_valid[0];
         r_slot_reg[1]   <= r_slot_reg[0];
         r_slot_valid[0] <= w_issue;
         r_slot_reg[0]   <= id_dest_reg;
         if (w_stall && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_ONE;
         end
      end
   end

   assign stall          = w_stall;
   assign inflight_valid = r_slot_valid;
   assign stall_count    = r_stall_count;

endmodule
